// File: rtl/vjtag_bus_ctrl.sv
// Virtual-JTAG command sequencer: scans host commands in, runs one req/ack bus transaction per CMD update.
// Optional bus timeout is built when VJTAG_BUS_CTRL_TIMEOUT_EN is defined.
module vjtag_bus_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              tck,
    input  logic              reset,
    input  logic              tdi,
    output logic              tdo,
    input  logic [1:0]        ir_in,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_udr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    // state | meaning
    // IDLE  | no transaction outstanding, CMD update launches one
    // REQ   | bus_req asserted, waiting for bus_ack (or timeout)
    typedef enum logic {IDLE, REQ} state_t;

    localparam int W = 1 + ADDR_W + DATA_W;

    state_t              state;
    state_t              state_nxt;
    logic                busy;
    logic                expire;
    logic                timeout_bit;
    logic [W-1:0]        cmd_sr;
    logic [7:0]          stat_sr;
    logic                bypass_reg;
    logic [DATA_W-1:0]   last_rdata;
    logic [ADDR_W-1:0]   last_addr;
    logic                last_we;
    logic                overrun_flag;
    logic [3:0]          count;

    wire cmd_sel  = (ir_in == 2'd1);
    wire stat_sel = (ir_in == 2'd2);
    wire cmd_cdr  = virtual_state_cdr && cmd_sel;
    wire cmd_sdr  = virtual_state_sdr && cmd_sel;
    wire cmd_udr  = virtual_state_udr && cmd_sel;
    wire stat_cdr = virtual_state_cdr && stat_sel;
    wire stat_sdr = virtual_state_sdr && stat_sel;
    wire stat_udr = virtual_state_udr && stat_sel;

`ifdef VJTAG_BUS_CTRL_TIMEOUT_EN
    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT - 1);

    // Down-counter loaded at launch; terminal count 0 marks the TIMEOUT-th REQ cycle.
    logic [7:0] timer;
    logic       timeout_flag;

    assign expire      = (state == REQ) && (timer == 8'd0) && !bus_ack;
    assign timeout_bit = timeout_flag;
`else
    assign expire      = 1'b0;
    assign timeout_bit = 1'b0;
`endif

    always_ff @(posedge tck) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_udr) state_nxt = REQ;
            REQ:     if (bus_ack || expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == REQ);
        bus_req = (state == REQ);
    end

    always_comb begin
        if (cmd_sel)       tdo = cmd_sr[0];
        else if (stat_sel) tdo = stat_sr[0];
        else               tdo = bypass_reg;
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            cmd_sr       <= '0;
            stat_sr      <= '0;
            bypass_reg   <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            last_rdata   <= '0;
            last_addr    <= '0;
            last_we      <= 1'b0;
            overrun_flag <= 1'b0;
            count        <= '0;
`ifdef VJTAG_BUS_CTRL_TIMEOUT_EN
            timer        <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            bypass_reg <= tdi;

            if (cmd_cdr)      cmd_sr <= {last_rdata, last_addr, busy};
            else if (cmd_sdr) cmd_sr <= {tdi, cmd_sr[W-1:1]};

            if (stat_cdr)      stat_sr <= {count, last_we, overrun_flag, timeout_bit, busy};
            else if (stat_sdr) stat_sr <= {tdi, stat_sr[7:1]};

            // Sticky clears first so a same-edge event still sets its flag.
            if (stat_udr) begin
                overrun_flag <= 1'b0;
`ifdef VJTAG_BUS_CTRL_TIMEOUT_EN
                timeout_flag <= 1'b0;
`endif
            end

            if (state == IDLE && cmd_udr) begin
                bus_we    <= cmd_sr[0];
                bus_addr  <= cmd_sr[ADDR_W:1];
                bus_wdata <= cmd_sr[W-1:ADDR_W+1];
`ifdef VJTAG_BUS_CTRL_TIMEOUT_EN
                timer     <= TIMER_LOAD;
`endif
            end

            if (state == REQ) begin
                if (cmd_udr) overrun_flag <= 1'b1;
`ifdef VJTAG_BUS_CTRL_TIMEOUT_EN
                if (timer != 8'd0) timer <= timer - 8'd1;
`endif
                if (bus_ack) begin
                    count     <= count + 4'd1;
                    last_addr <= bus_addr;
                    last_we   <= bus_we;
                    if (!bus_we) last_rdata <= bus_rdata;
                end
`ifdef VJTAG_BUS_CTRL_TIMEOUT_EN
                else if (expire) begin
                    timeout_flag <= 1'b1;
                    last_rdata   <= '0;
                end
`endif
            end
        end
    end

endmodule
